// File: rtl/hex_msg_scroller.sv
// Scrolling message driver for a row of 7-segment digits: a writable character buffer
// rotates across the display one position per prescaled tick, or per step while held.
module hex_msg_scroller #(
    parameter int NUM_DIGITS     = 4,
    parameter int MSG_LEN        = 8,
    parameter int TICK_DIV       = 50_000_000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    localparam int AW            = $clog2(MSG_LEN)
) (
    input  logic                    CLOCK_50,
    input  logic                    RESET,
    input  logic                    run,
    input  logic                    dir,
    input  logic                    step,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [4:0]              wr_data,
    output logic [AW-1:0]           pos,
    output logic                    tick_o,
    output logic [7*NUM_DIGITS-1:0] HEX
);
    localparam int              PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [AW-1:0]   POS_LAST   = AW'(MSG_LEN - 1);
    localparam logic [6:0]      SEG_OFF    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [4:0]      CHAR_BLANK = 5'h10;

    typedef enum logic {ST_HOLD = 1'b0, ST_RUN = 1'b1} state_t;

    state_t                  state_r, state_nxt_s;
    logic [PW-1:0]           presc_r, presc_nxt_s;
    logic [AW-1:0]           pos_r, pos_nxt_s;
    logic                    advance_s;
    logic                    tick_r;
    logic                    wr_hit_s;
    logic [4:0]              msg_r [MSG_LEN];
    logic [AW-1:0]           idx_s [NUM_DIGITS];
    logic [7*NUM_DIGITS-1:0] hex_r, hex_nxt_s;

    // Character code to segment pattern (a..g in bits 6..0), built active-low then polarised.
    function automatic logic [6:0] seg_decode(input logic [4:0] code);
        logic [6:0] low;
        case (code)
            5'h00:   low = 7'b0000001;
            5'h01:   low = 7'b1001111;
            5'h02:   low = 7'b0010010;
            5'h03:   low = 7'b0000110;
            5'h04:   low = 7'b1001100;
            5'h05:   low = 7'b0100100;
            5'h06:   low = 7'b0100000;
            5'h07:   low = 7'b0001111;
            5'h08:   low = 7'b0000000;
            5'h09:   low = 7'b0000100;
            5'h0A:   low = 7'b0001000;
            5'h0B:   low = 7'b1100000;
            5'h0C:   low = 7'b0110001;
            5'h0D:   low = 7'b1000010;
            5'h0E:   low = 7'b0110000;
            5'h0F:   low = 7'b0111000;
            5'h11:   low = 7'b1111110;
            5'h12:   low = 7'b1001000;
            5'h13:   low = 7'b1110001;
            5'h14:   low = 7'b0011000;
            5'h15:   low = 7'b1000001;
            default: low = 7'b1111111;
        endcase
        return SEG_ACTIVE_LOW ? low : ~low;
    endfunction

    assign wr_hit_s = wr_en & (int'(wr_addr) < MSG_LEN);

    // Run/hold sequencing; leaving RUN discards any partial prescaler count.
    always_comb begin
        state_nxt_s = state_r;
        presc_nxt_s = {PW{1'b0}};
        advance_s   = 1'b0;
        case (state_r)
            ST_HOLD: begin
                advance_s = step;
                if (run) state_nxt_s = ST_RUN;
                else     state_nxt_s = ST_HOLD;
            end
            ST_RUN: begin
                if (!run)                      state_nxt_s = ST_HOLD;
                else if (presc_r == PRESC_LAST) advance_s = 1'b1;
                else                            presc_nxt_s = presc_r + PW'(1);
            end
            default: state_nxt_s = ST_HOLD;
        endcase
    end

    // Wrapping scroll offset, direction sampled at the advancing edge.
    always_comb begin
        pos_nxt_s = pos_r;
        if (advance_s) begin
            if (dir) pos_nxt_s = (pos_r == {AW{1'b0}}) ? POS_LAST : pos_r - AW'(1);
            else     pos_nxt_s = (pos_r == POS_LAST) ? {AW{1'b0}} : pos_r + AW'(1);
        end else begin
            pos_nxt_s = pos_r;
        end
    end

    // Digit i (0 = rightmost) shows the character NUM_DIGITS-1-i places after pos.
    always_comb begin
        hex_nxt_s = {NUM_DIGITS{SEG_OFF}};
        for (int i = 0; i < NUM_DIGITS; i++) begin
            idx_s[i] = AW'((int'(pos_r) + NUM_DIGITS - 1 - i) % MSG_LEN);
            hex_nxt_s[7*i +: 7] = seg_decode(msg_r[idx_s[i]]);
        end
    end

    // Control and output registers.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_r <= ST_HOLD;
            presc_r <= {PW{1'b0}};
            pos_r   <= {AW{1'b0}};
            tick_r  <= 1'b0;
            hex_r   <= {NUM_DIGITS{SEG_OFF}};
        end else begin
            state_r <= state_nxt_s;
            presc_r <= presc_nxt_s;
            pos_r   <= pos_nxt_s;
            tick_r  <= advance_s;
            hex_r   <= hex_nxt_s;
        end
    end

    // Message buffer; out-of-range addresses are dropped.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            for (int k = 0; k < MSG_LEN; k++) msg_r[k] <= CHAR_BLANK;
        end else if (wr_hit_s) begin
            msg_r[wr_addr] <= wr_data;
        end
    end

    assign pos    = pos_r;
    assign tick_o = tick_r;
    assign HEX    = hex_r;
endmodule

// File: tb/tb_hex_msg_scroller.sv
// Self-checking bench for hex_msg_scroller: a behavioural model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_hex_msg_scroller;
    localparam int TICK_DIV = 4;
    localparam int NDIG     = 4;
    localparam int MLEN     = 8;

    logic        CLOCK_50 = 1'b0;
    logic        RESET    = 1'b1;
    logic        run = 1'b0, dir = 1'b0, step = 1'b0, wr_en = 1'b0;
    logic [2:0]  wr_addr = 3'd0;
    logic [4:0]  wr_data = 5'd0;
    logic [2:0]  pos;
    logic        tick_o;
    logic [27:0] HEX;

    int n_tests = 0;
    int n_fail  = 0;

    hex_msg_scroller #(.NUM_DIGITS(NDIG), .MSG_LEN(MLEN), .TICK_DIV(TICK_DIV), .SEG_ACTIVE_LOW(1'b1)) dut (
        .CLOCK_50(CLOCK_50), .RESET(RESET), .run(run), .dir(dir), .step(step),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pos(pos), .tick_o(tick_o), .HEX(HEX)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [6:0]  pat [32];
    int          m_buf [MLEN];
    int          m_pos;
    logic        m_tick;
    logic [27:0] m_hex;
    bit          m_in_run;
    int          m_run_cycles;
    bit          m_adv;

    initial begin
        for (int c = 0; c < 32; c++) pat[c] = 7'b1111111;
        pat[0]  = 7'b0000001; pat[1]  = 7'b1001111; pat[2]  = 7'b0010010; pat[3]  = 7'b0000110;
        pat[4]  = 7'b1001100; pat[5]  = 7'b0100100; pat[6]  = 7'b0100000; pat[7]  = 7'b0001111;
        pat[8]  = 7'b0000000; pat[9]  = 7'b0000100; pat[10] = 7'b0001000; pat[11] = 7'b1100000;
        pat[12] = 7'b0110001; pat[13] = 7'b1000010; pat[14] = 7'b0110000; pat[15] = 7'b0111000;
        pat[17] = 7'b1111110; pat[18] = 7'b1001000; pat[19] = 7'b1110001; pat[20] = 7'b0011000;
        pat[21] = 7'b1000001;
    end

    function automatic logic [27:0] render();
        logic [27:0] h;
        for (int i = 0; i < NDIG; i++) h[7*i +: 7] = pat[m_buf[(m_pos + NDIG - 1 - i) % MLEN]];
        return h;
    endfunction

    // Model: ticks come every TICK_DIV cycles spent in run, counted from the entry edge.
    initial forever begin
        @(posedge CLOCK_50 or posedge RESET);
        if (RESET) begin
            m_pos = 0; m_tick = 1'b0; m_in_run = 1'b0; m_run_cycles = 0; m_hex = '1;
            for (int k = 0; k < MLEN; k++) m_buf[k] = 16;
        end else begin
            m_hex = render();
            m_adv = 1'b0;
            if (m_in_run) begin
                if (run) begin
                    m_run_cycles++;
                    m_adv = (m_run_cycles % TICK_DIV) == 0;
                end else begin
                    m_in_run = 1'b0;
                end
            end else begin
                m_adv = step;
                if (run) begin
                    m_in_run = 1'b1;
                    m_run_cycles = 0;
                end
            end
            if (m_adv) m_pos = dir ? (m_pos + MLEN - 1) % MLEN : (m_pos + 1) % MLEN;
            if (wr_en && int'(wr_addr) < MLEN) m_buf[wr_addr] = int'(wr_data);
            m_tick = m_adv;
        end
    end

    initial forever begin
        @(negedge CLOCK_50);
        check("cyc_pos", 32'(pos), 32'(m_pos));
        check("cyc_tick", 32'(tick_o), 32'(m_tick));
        check("cyc_hex", 32'(HEX), 32'(m_hex));
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_tick(output int cycles);
        cycles = 0;
        do begin
            @(negedge CLOCK_50);
            cycles++;
        end while (tick_o !== 1'b1 && cycles < 12);
        if (tick_o !== 1'b1) begin
            n_tests++; n_fail++;
            $display("FAIL tick_timeout: got no tick in %0d cycles expected tick", cycles);
        end
    endtask

    // ---------------- directed scenarios ----------------
    logic [4:0] codes [7];
    logic [3:0] addr9;
    int c, cnt;

    initial begin
        codes[0] = 5'h00; codes[1] = 5'h01; codes[2] = 5'h0E; codes[3] = 5'h0D;
        codes[4] = 5'h12; codes[5] = 5'h11; codes[6] = 5'h15;
        repeat (3) @(negedge CLOCK_50);
        RESET = 1'b0;

        // Idle after reset
        repeat (20) begin
            @(negedge CLOCK_50);
            check("idle_pos", 32'(pos), 32'd0);
            check("idle_tick", 32'(tick_o), 32'd0);
            check("idle_hex", 32'(HEX), 32'h0FFFFFFF);
        end

        // Load message while holding
        for (int k = 0; k < 7; k++) begin
            wr_en = 1'b1; wr_addr = 3'(k); wr_data = codes[k];
            @(negedge CLOCK_50);
        end
        wr_en = 1'b0;
        @(negedge CLOCK_50);
        check("load_hex", 32'(HEX), 32'(28'b0000001_1001111_0110000_1000010));

        // Auto-scroll left with wrap
        run = 1'b1; dir = 1'b0;
        for (int t = 1; t <= 12; t++) begin
            wait_tick(c);
            check("run_pos", 32'(pos), 32'(t % 8));
            if (t > 1) check("run_period", 32'(c), 32'd4);
        end
        check("wrap_plus4", 32'(pos), 32'd4);

        // Reverse direction from pos 0
        repeat (4) wait_tick(c);
        check("pos_zero", 32'(pos), 32'd0);
        dir = 1'b1;
        wait_tick(c);
        check("rev_pos", 32'(pos), 32'd7);
        check("rev_period", 32'(c), 32'd4);
        @(negedge CLOCK_50);
        check("rev_dig3", 32'(HEX[27:21]), 32'(7'b1111111));
        check("rev_dig2", 32'(HEX[20:14]), 32'(7'b0000001));
        check("rev_dig1", 32'(HEX[13:7]), 32'(7'b1001111));
        check("rev_dig0", 32'(HEX[6:0]), 32'(7'b0110000));

        // Single-step in hold
        run = 1'b0; dir = 1'b0;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        check("hold_pos", 32'(pos), 32'd7);
        cnt = 0;
        repeat (3) begin
            step = 1'b1;
            @(negedge CLOCK_50);
            if (tick_o) cnt++;
            step = 1'b0;
            repeat (2) begin
                @(negedge CLOCK_50);
                if (tick_o) cnt++;
            end
        end
        check("step_ticks", 32'(cnt), 32'd3);
        check("step_pos", 32'(pos), 32'd2);

        // Step ignored while running
        run = 1'b1;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        step = 1'b1;
        @(negedge CLOCK_50);
        step = 1'b0;
        check("runstep_tick", 32'(tick_o), 32'd0);
        check("runstep_pos", 32'(pos), 32'd2);
        @(negedge CLOCK_50);
        check("runstep_tick2", 32'(tick_o), 32'd0);

        // Reset mid-count at pos 5, with a write to address 9 in flight
        repeat (3) wait_tick(c);
        check("pre_rst_pos", 32'(pos), 32'd5);
        @(negedge CLOCK_50);
        @(posedge CLOCK_50);
        #1;
        RESET = 1'b1;
        addr9 = 4'd9;
        wr_en = 1'b1; wr_addr = addr9[2:0]; wr_data = 5'h08;
        #1;
        check("rst_pos", 32'(pos), 32'd0);
        check("rst_tick", 32'(tick_o), 32'd0);
        check("rst_hex", 32'(HEX), 32'h0FFFFFFF);
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        run = 1'b0; wr_en = 1'b0; RESET = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        check("post_rst_hex", 32'(HEX), 32'h0FFFFFFF);
        check("post_rst_pos", 32'(pos), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
